frequency_lock_controller: RTL and testbench

//  Sequences one frequency_regulator instance through acquire/track/lock.
//  - Latches a user target period on start, drives the regulator's setPeriod and its sync reset.
//  - Watches each PSI falling edge and the regulator's inc/dec verdict, and counts consecutive matches.
//  - Declares lock, tracks loss of lock, and flags timeout or divider-saturation faults.
//  - Sits between the user control registers and the regulator.

---
 rtl/freq_ctrl_pkg.sv | 29 ++
 rtl/psi_fall_detect.sv | 21 ++
 rtl/frequency_lock_controller.sv | 151 +++++++++++++++
 tb/tb_frequency_lock_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/freq_ctrl_pkg.sv
// freq_ctrl_pkg: shared states, regulator verdict codes and fault codes
// for the frequency lock controller.
package freq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ACQUIRE,
        ST_LOCKED,
        ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_TIMEOUT,
        FC_SAT,
        FC_ZERO
    } fault_e;

    localparam logic [1:0] VD_INC  = 2'b11;
    localparam logic [1:0] VD_DEC  = 2'b00;
    localparam logic [1:0] VD_HOLD = 2'b10;

    // Regulator wants to move the divider past its range limit
    function automatic logic div_saturated(input logic [1:0] verdict, input logic [7:0] div);
        return (div == 8'hFF && verdict == VD_INC) || (div == 8'h00 && verdict == VD_DEC);
    endfunction

endpackage

// File: rtl/psi_fall_detect.sv
// psi_fall_detect: registers psi and flags its falling edge; the history is
// cleared while the regulator is in reset so both see the same previous value.
module psi_fall_detect (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic psi,
    output logic fall
);

    logic psi_d_q, psi_d_d;

    always_comb psi_d_d = clr ? 1'b0 : psi;

    always_ff @(posedge clk or negedge rst)
        if (!rst) psi_d_q <= 1'b0;
        else      psi_d_q <= psi_d_d;

    assign fall = psi_d_q & ~psi;

endmodule

// File: rtl/frequency_lock_controller.sv
// frequency_lock_controller: sequences a frequency_regulator through
// reset, acquisition and lock, and reports timeout / saturation faults.
module frequency_lock_controller
    import freq_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned LOSS_COUNT    = 2,
    parameter int unsigned TIMEOUT_EDGES = 200,
    parameter int unsigned RST_CYCLES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] target_period,
    input  logic       psi,
    input  logic [1:0] inc_dec,
    input  logic [7:0] adjusted_div,
    output logic       reg_rst,
    output logic [7:0] set_period,
    output logic       busy,
    output logic       locked,
    output logic       fault,
    output logic [1:0] fault_code,
    output logic [7:0] lock_div
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $clog2(LOSS_COUNT + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);
    localparam logic [LW-1:0] LOSS_N = LW'(LOSS_COUNT);
    localparam logic [RW-1:0] RST_N  = RW'(RST_CYCLES);
    localparam logic [7:0]    TO_N   = 8'(TIMEOUT_EDGES);

    state_e          state_q, state_d;
    fault_e          fault_code_q, fault_code_d;
    logic [7:0]      set_period_q, set_period_d;
    logic [7:0]      lock_div_q, lock_div_d;
    logic [MW-1:0]   match_q, match_d;
    logic [LW-1:0]   miss_q, miss_d;
    logic [7:0]      edge_q, edge_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            fall;
    logic            hold;

    psi_fall_detect u_fall (
        .clk  (clk),
        .rst  (rst),
        .clr  (reg_rst),
        .psi  (psi),
        .fall (fall)
    );

    assign hold = (inc_dec == VD_HOLD);

    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        set_period_d = set_period_q;
        lock_div_d   = lock_div_q;
        match_d      = match_q;
        miss_d       = miss_q;
        edge_d       = edge_q;
        rcnt_d       = rcnt_q;
        if (abort) begin
            state_d      = ST_IDLE;
            fault_code_d = FC_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAULT: if (start) begin
                    set_period_d = target_period;
                    match_d      = '0;
                    miss_d       = '0;
                    edge_d       = '0;
                    rcnt_d       = '0;
                    state_d      = (target_period == 8'd0) ? ST_FAULT : ST_START;
                    fault_code_d = (target_period == 8'd0) ? FC_ZERO : FC_NONE;
                end
                ST_START: begin
                    rcnt_d  = rcnt_q + 1'b1;
                    state_d = (rcnt_q == RST_N - 1'b1) ? ST_ACQUIRE : ST_START;
                end
                ST_ACQUIRE: if (fall) begin
                    if (div_saturated(inc_dec, adjusted_div)) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_SAT;
                    end else begin
                        edge_d  = (edge_q == 8'hFF) ? edge_q : edge_q + 8'd1;
                        match_d = !hold ? '0 : (match_q == LOCK_N) ? match_q : match_q + 1'b1;
                        if (match_d == LOCK_N) begin
                            state_d    = ST_LOCKED;
                            lock_div_d = adjusted_div;
                            miss_d     = '0;
                        end else if (edge_d >= TO_N) begin
                            state_d      = ST_FAULT;
                            fault_code_d = FC_TIMEOUT;
                        end
                    end
                end
                ST_LOCKED: if (fall) begin
                    if (div_saturated(inc_dec, adjusted_div)) begin
                        state_d      = ST_FAULT;
                        fault_code_d = FC_SAT;
                    end else begin
                        miss_d = hold ? '0 : (miss_q == LOSS_N) ? miss_q : miss_q + 1'b1;
                        if (miss_d == LOSS_N) begin
                            state_d = ST_ACQUIRE;
                            match_d = '0;
                            edge_d  = '0;
                            miss_d  = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            fault_code_q <= FC_NONE;
            set_period_q <= '0;
            lock_div_q   <= '0;
            match_q      <= '0;
            miss_q       <= '0;
            edge_q       <= '0;
            rcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            set_period_q <= set_period_d;
            lock_div_q   <= lock_div_d;
            match_q      <= match_d;
            miss_q       <= miss_d;
            edge_q       <= edge_d;
            rcnt_q       <= rcnt_d;
        end
    end

    // Regulator runs only while acquiring or locked
    assign reg_rst    = !(state_q inside {ST_ACQUIRE, ST_LOCKED});
    assign busy       = state_q inside {ST_START, ST_ACQUIRE, ST_LOCKED};
    assign locked     = (state_q == ST_LOCKED);
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fault_code_q;
    assign set_period = set_period_q;
    assign lock_div   = lock_div_q;

endmodule

// File: tb/tb_frequency_lock_controller.sv
// tb_frequency_lock_controller: directed sequence with a scoreboard queue of
// expected status / period / divider values checked by immediate assertions.
module tb_frequency_lock_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, psi;
    logic [7:0] target_period, adjusted_div;
    logic [1:0] inc_dec;
    logic       reg_rst, busy, locked, fault;
    logic [7:0] set_period, lock_div;
    logic [1:0] fault_code;

    localparam logic [1:0] INC = 2'b11, DEC = 2'b00, HOLD = 2'b10;
    // status = {reg_rst, busy, locked, fault, fault_code}
    localparam logic [15:0] S_IDLE = 16'b100000, S_START = 16'b110000;
    localparam logic [15:0] S_ACQ  = 16'b010000, S_LOCK  = 16'b011000;
    localparam logic [15:0] S_F_TO = 16'b100101, S_F_SAT = 16'b100110, S_F_ZERO = 16'b100111;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    frequency_lock_controller dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .target_period (target_period),
        .psi           (psi),
        .inc_dec       (inc_dec),
        .adjusted_div  (adjusted_div),
        .reg_rst       (reg_rst),
        .set_period    (set_period),
        .busy          (busy),
        .locked        (locked),
        .fault         (fault),
        .fault_code    (fault_code),
        .lock_div      (lock_div)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] st();
        return {10'd0, reg_rst, busy, locked, fault, fault_code};
    endfunction

    task automatic push(input string t, input logic [15:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic pop_chk(input logic [15:0] obs);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: got %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                n_err++;
                $error("FAIL %s: got %h required %h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic do_start(input logic [7:0] t);
        start = 1'b1;
        target_period = t;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // psi high for hi clocks, then low: the fall is consumed on the next edge
    task automatic do_fall(input logic [1:0] v, input logic [7:0] d, input int hi);
        inc_dec = v;
        adjusted_div = d;
        psi = 1'b1;
        repeat (hi) @(negedge clk);
        psi = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; psi = 1'b0;
        target_period = 8'd0; adjusted_div = 8'h80; inc_dec = INC;
        #12;
        push("reset_status", S_IDLE);   pop_chk(st());
        push("reset_period", 16'd0);    pop_chk({8'd0, set_period});
        push("reset_lockdiv", 16'd0);   pop_chk({8'd0, lock_div});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        push("start_status", S_START);  push("start_period", 16'd20);
        do_start(8'd20);
        pop_chk(st());                  pop_chk({8'd0, set_period});
        push("start_hold2", S_START);
        @(negedge clk);                 pop_chk(st());
        push("acq_entry", S_ACQ);
        @(negedge clk);                 pop_chk(st());

        do_fall(INC, 8'h40, 20);
        repeat (3) do_fall(HOLD, 8'h40, 20);
        push("three_holds", S_ACQ);     pop_chk(st());
        push("match_reset", S_ACQ);
        do_fall(INC, 8'h40, 20);        pop_chk(st());
        repeat (3) do_fall(HOLD, 8'h48, 20);
        push("lock_status", S_LOCK);    push("lock_div", 16'h0055);
        do_fall(HOLD, 8'h55, 20);
        pop_chk(st());                  pop_chk({8'd0, lock_div});

        push("start_in_locked", S_LOCK); push("period_kept", 16'd20);
        do_start(8'd99);
        pop_chk(st());                  pop_chk({8'd0, set_period});

        push("miss_one", S_LOCK);
        do_fall(INC, 8'h55, 25);        pop_chk(st());
        push("miss_cleared", S_LOCK);
        do_fall(HOLD, 8'h55, 25);       pop_chk(st());
        do_fall(INC, 8'h55, 25);
        push("loss_status", S_ACQ);     push("loss_lockdiv", 16'h0055);
        do_fall(INC, 8'h56, 25);
        pop_chk(st());                  pop_chk({8'd0, lock_div});

        push("abort_status", S_IDLE);   push("abort_period", 16'd20); push("abort_lockdiv", 16'h0055);
        do_abort();
        pop_chk(st());                  pop_chk({8'd0, set_period}); pop_chk({8'd0, lock_div});

        push("start_abort_status", S_IDLE); push("start_abort_period", 16'd20);
        abort = 1'b1;
        do_start(8'd77);
        abort = 1'b0;
        pop_chk(st());                  pop_chk({8'd0, set_period});

        do_start(8'd30);
        repeat (2) @(negedge clk);
        repeat (199) do_fall(INC, 8'h80, 1);
        push("edge199", S_ACQ);         pop_chk(st());
        push("timeout", S_F_TO);
        do_fall(INC, 8'h80, 1);         pop_chk(st());

        push("refault_start", S_START); push("refault_period", 16'd30);
        do_start(8'd30);
        pop_chk(st());                  pop_chk({8'd0, set_period});
        repeat (2) @(negedge clk);
        repeat (196) do_fall(INC, 8'h80, 1);
        repeat (3) do_fall(HOLD, 8'h80, 1);
        push("lock_vs_timeout", S_LOCK); push("lock_div2", 16'h0066);
        do_fall(HOLD, 8'h66, 1);
        pop_chk(st());                  pop_chk({8'd0, lock_div});

        push("sat_inc", S_F_SAT);
        do_fall(INC, 8'hFF, 1);         pop_chk(st());

        push("zero_target", S_F_ZERO);  push("zero_period", 16'd0);
        do_start(8'd0);
        pop_chk(st());                  pop_chk({8'd0, set_period});
        push("zero_no_start", S_F_ZERO);
        @(negedge clk);                 pop_chk(st());
        push("abort_fault", S_IDLE);
        do_abort();                     pop_chk(st());

        do_start(8'd20);
        repeat (2) @(negedge clk);
        push("sat_dec", S_F_SAT);
        do_fall(DEC, 8'h00, 1);         pop_chk(st());
        do_abort();

        do_start(8'd20);
        repeat (2) @(negedge clk);
        push("pre_reset_acq", S_ACQ);   pop_chk(st());
        push("async_reset", S_IDLE);    push("async_period", 16'd0);
        #2 rst = 1'b0;
        #1;
        pop_chk(st());                  pop_chk({8'd0, set_period});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
